// File: rtl/canvas_write_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : canvas_pkg
// Brief   : Shared constants and state type for the canvas write scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package canvas_pkg;
  localparam int CANVAS_DIM = 128;
  localparam int ADDR_W     = 14;
  localparam int COLOR_W    = 9;

  localparam logic [COLOR_W-1:0] WHITE = 9'h1FF;
  localparam logic [COLOR_W-1:0] BLACK = 9'h000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STAMP = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } sched_state_t;
endpackage
`default_nettype wire

// File: rtl/canvas_write_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : canvas_write_scheduler_if
// Brief   : Control-input and framebuffer-write bundle of the scheduler.
//           master = control/framebuffer side, slave = scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface canvas_write_scheduler_if #(
  parameter int COORD_W = 7,
  parameter int COLOR_W = 9
);
  logic [COORD_W-1:0]   mouse_x;
  logic [COORD_W-1:0]   mouse_y;
  logic                 mouse_click;
  logic [1:0]           brush_size;
  logic [COLOR_W-1:0]   color;
  logic                 clear_req;
  logic                 fb_stall;
  logic                 wr_en;
  logic [2*COORD_W-1:0] wr_addr;
  logic [COLOR_W-1:0]   wr_data;
  logic                 busy;
  logic                 done;

  modport master (
    output mouse_x, mouse_y, mouse_click, brush_size, color, clear_req, fb_stall,
    input  wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  mouse_x, mouse_y, mouse_click, brush_size, color, clear_req, fb_stall,
    output wr_en, wr_addr, wr_data, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/canvas_write_scheduler_brush_walker.sv
`default_nettype none
// ============================================================================
// Module  : brush_walker
// Brief   : Offset counter. 2-D mode: dx in bits [1:0], dy in bits [3:2],
//           each running 0..size with dx fastest. Linear mode: plain count
//           over the full CNT_W range. Exposes the post-step value so the
//           owner can register the next target ahead of time.
// Revision: 1.0 - initial release
// ============================================================================
module brush_walker #(
  parameter int CNT_W = 14
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start_i,
  input  wire logic             step_i,
  input  wire logic             linear_i,
  input  wire logic [1:0]       size_i,
  output logic      [CNT_W-1:0] nxt_cnt_o,
  output logic                  last_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dx, dy;

  assign dx = cnt_q[1:0];
  assign dy = cnt_q[3:2];

  // Value the counter takes after one step in the current mode.
  always_comb begin
    nxt_cnt_o = cnt_q + CNT_W'(1);
    if (!linear_i) begin
      if (dx == size_i) nxt_cnt_o = {{(CNT_W-4){1'b0}}, dy + 2'd1, 2'b00};
      else              nxt_cnt_o = {{(CNT_W-4){1'b0}}, dy, dx + 2'd1};
    end
  end

  assign last_o = linear_i ? (&cnt_q) : ((dx == size_i) && (dy == size_i));

  // Restart at zero, advance on step, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i)     cnt_d = '0;
    else if (step_i) cnt_d = nxt_cnt_o;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule
`default_nettype wire

// File: rtl/canvas_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : canvas_write_scheduler
// Brief   : Turns brush clicks into per-pixel framebuffer writes over the
//           brush square (clipped at the canvas edge), yielding to fb_stall.
//           Optional full-canvas clear sweep when CLEAR_SWEEP_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module canvas_write_scheduler #(
  parameter int                 COORD_W     = 7,
  parameter int                 COLOR_W     = 9,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = canvas_pkg::WHITE
) (
  input wire logic                 clk,
  input wire logic                 rst,
  canvas_write_scheduler_if.slave  bus
);
  import canvas_pkg::*;

  localparam int AW = 2 * COORD_W;

  sched_state_t         state_q, state_d;
  logic [COORD_W-1:0]   cap_x_q, cap_y_q, rec_x_q, rec_y_q;
  logic [1:0]           cap_size_q, rec_size_q;
  logic [COLOR_W-1:0]   cap_color_q, rec_color_q, wr_data_q;
  logic                 rec_valid_q, from_clear_q, pix_ok_q;
  logic [AW-1:0]        wr_addr_q;
  logic                 walk_start, walk_step, walk_last, linear;
  logic                 load_first, load_next, enter_clear, clr_go, tuple_new, nxt_ok;
  logic [AW-1:0]        nxt_cnt, nxt_addr;
  logic [COORD_W:0]     tx, ty;

  brush_walker #(.CNT_W(AW)) u_walker (
    .clk       (clk),
    .rst       (rst),
    .start_i   (walk_start),
    .step_i    (walk_step),
    .linear_i  (linear),
    .size_i    (cap_size_q),
    .nxt_cnt_o (nxt_cnt),
    .last_o    (walk_last)
  );

`ifdef CLEAR_SWEEP_EN
  logic pend_q;
  assign clr_go = pend_q | bus.clear_req;

  // Pending clear: set by any request, consumed when the sweep starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          pend_q <= 1'b0;
    else if (enter_clear)              pend_q <= 1'b0;
    else if (bus.clear_req)            pend_q <= 1'b1;
  end
`else
  logic unused_clear_req;
  assign unused_clear_req = bus.clear_req;
  assign clr_go           = 1'b0;
`endif

  assign linear    = (state_q == CLEAR);
  assign tuple_new = !rec_valid_q ||
                     ({bus.mouse_x, bus.mouse_y, bus.brush_size, bus.color} !=
                      {rec_x_q, rec_y_q, rec_size_q, rec_color_q});

  // Next target is one bit wider than a coordinate so overflow means off-canvas.
  assign tx       = {1'b0, cap_x_q} + {{(COORD_W-1){1'b0}}, nxt_cnt[1:0]};
  assign ty       = {1'b0, cap_y_q} + {{(COORD_W-1){1'b0}}, nxt_cnt[3:2]};
  assign nxt_ok   = linear | (~tx[COORD_W] & ~ty[COORD_W]);
  assign nxt_addr = linear ? nxt_cnt : {ty[COORD_W-1:0], tx[COORD_W-1:0]};

  // Next-state and sequencing strobes.
  always_comb begin
    state_d     = state_q;
    walk_start  = 1'b0;
    walk_step   = 1'b0;
    load_first  = 1'b0;
    load_next   = 1'b0;
    enter_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_go) begin
          state_d     = CLEAR;
          walk_start  = 1'b1;
          enter_clear = 1'b1;
        end else if (bus.mouse_click && tuple_new) begin
          state_d    = STAMP;
          walk_start = 1'b1;
          load_first = 1'b1;
        end
      end
      STAMP, CLEAR: begin
        if (!bus.fb_stall) begin
          walk_step = 1'b1;
          if (walk_last) state_d   = DONE;
          else           load_next = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Brush capture at burst start and last-stamp record for repeat suppression.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_x_q      <= '0;
      cap_y_q      <= '0;
      cap_size_q   <= '0;
      cap_color_q  <= '0;
      from_clear_q <= 1'b0;
      rec_valid_q  <= 1'b0;
      rec_x_q      <= '0;
      rec_y_q      <= '0;
      rec_size_q   <= '0;
      rec_color_q  <= '0;
    end else begin
      if (load_first) begin
        cap_x_q      <= bus.mouse_x;
        cap_y_q      <= bus.mouse_y;
        cap_size_q   <= bus.brush_size;
        cap_color_q  <= bus.color;
        from_clear_q <= 1'b0;
      end else if (enter_clear) begin
        from_clear_q <= 1'b1;
      end
      if (state_q == IDLE && !bus.mouse_click) begin
        rec_valid_q <= 1'b0;
      end else if (state_q == DONE) begin
        rec_valid_q <= !from_clear_q;
        rec_x_q     <= cap_x_q;
        rec_y_q     <= cap_y_q;
        rec_size_q  <= cap_size_q;
        rec_color_q <= cap_color_q;
      end
    end
  end

  // Presented pixel: loaded one step ahead; address only moves to in-range targets.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pix_ok_q  <= 1'b0;
    end else if (load_first) begin
      wr_addr_q <= {bus.mouse_y, bus.mouse_x};
      wr_data_q <= bus.color;
      pix_ok_q  <= 1'b1;
    end else if (enter_clear) begin
      wr_addr_q <= '0;
      wr_data_q <= CLEAR_COLOR;
      pix_ok_q  <= 1'b1;
    end else if (load_next) begin
      pix_ok_q <= nxt_ok;
      if (nxt_ok) wr_addr_q <= nxt_addr;
    end
  end

  assign bus.wr_en   = (state_q == STAMP || state_q == CLEAR) && !bus.fb_stall && pix_ok_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
endmodule
`default_nettype wire

// File: tb/tb_canvas_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_canvas_write_scheduler
// Brief   : Scoreboard bench. Stimulus predicts the pixel list and done cycle
//           of each brush stamp from the brush geometry; a monitor pops and
//           compares whenever the scheduler writes or signals done.
// Revision: 1.0 - initial release
// ============================================================================
module tb_canvas_write_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscmp  = 0;

  logic [22:0] wq[$];   // {addr, data} in expected order
  int          dq[$];   // cycle in which done must be high

  bit          m_valid = 0;
  logic [24:0] m_tup   = '0;

  canvas_write_scheduler_if bus ();

  canvas_write_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_wr_en",   bus.wr_en,   0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_busy",    bus.busy,    0);
    chk("rst_done",    bus.done,    0);
  endtask

  // Expected pixels of a brush square, row by row, skipping off-canvas cells.
  task automatic push_stamp(input int x, input int y, input int s, input logic [8:0] c);
    for (int dy = 0; dy <= s; dy++)
      for (int dx = 0; dx <= s; dx++)
        if (x + dx < 128 && y + dy < 128)
          wq.push_back({7'(y + dy), 7'(x + dx), c});
  endtask

  // Monitor: compares every write and every done pulse against the queues.
  initial begin
    logic [22:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.fb_stall) chk("stall_no_write", bus.wr_en, 0);
        if (bus.wr_en) begin
          if (wq.size() == 0) chk("write_unexpected", {bus.wr_addr, bus.wr_data}, 32'hDEAD);
          else begin
            e = wq.pop_front();
            chk("write", {bus.wr_addr, bus.wr_data}, e);
          end
        end
        if (bus.done) begin
          if (dq.size() == 0) chk("done_unexpected", cyc, 0);
          else chk("done_cycle", cyc, dq.pop_front());
        end
        if (dq.size() > 0 && dq[0] < cyc) chk("done_missing", cyc, dq.pop_front());
      end
    end
  end

  // Called at posedge+1 of an IDLE cycle; returns the same way.
  task automatic do_op(input logic [6:0] x, input logic [6:0] y, input logic [1:0] s,
                       input logic [8:0] c, input int smode, input bit rel, input bit clr);
    int n, issued, per;
    bit st, stamp;
    if (rel) begin
      bus.mouse_click = 1'b0;
      m_valid = 0;
      @(posedge clk); #1;
    end
    bus.mouse_x = x; bus.mouse_y = y; bus.brush_size = s; bus.color = c;
    bus.mouse_click = 1'b1; bus.fb_stall = 1'b0;
    stamp = !m_valid || ({x, y, s, c} != m_tup);
    if (stamp) begin
      push_stamp(int'(x), int'(y), int'(s), c);
      n = (int'(s) + 1) * (int'(s) + 1);
      issued = 0; per = 0;
      while (issued < n) begin
        @(posedge clk); #1;
        per++;
        case (smode)
          0:       st = 0;
          1:       st = ($urandom_range(0, 3) == 0);
          default: st = (per >= 3 && per <= 5);
        endcase
        bus.fb_stall  = st;
        bus.clear_req = clr && (per == 1);
        if (!st) begin
          issued++;
          if (issued == n) dq.push_back(cyc + 1);
        end
        @(negedge clk); chk("busy_stamp", bus.busy, 1);
      end
      @(posedge clk); #1;
      bus.fb_stall = 1'b0; bus.clear_req = 1'b0;
      @(negedge clk); chk("busy_done", bus.busy, 1);
      m_valid = 1; m_tup = {x, y, s, c};
      @(posedge clk); #1;
      @(negedge clk); chk("busy_after", bus.busy, 0);
      if (clr) begin
        for (int a = 0; a < 16384; a++) wq.push_back({14'(a), 9'h1FF});
        issued = 0;
        while (issued < 16384) begin
          @(posedge clk); #1;
          bus.mouse_click = 1'b0;
          st = ($urandom_range(0, 15) == 0);
          bus.fb_stall = st;
          if (!st) begin
            issued++;
            if (issued == 16384) dq.push_back(cyc + 1);
          end
        end
        @(posedge clk); #1;
        bus.fb_stall = 1'b0;
        @(negedge clk); chk("busy_clear_done", bus.busy, 1);
        @(posedge clk); #1;
        m_valid = 0;
      end
    end else begin
      repeat (3) begin
        @(negedge clk); chk("busy_idle", bus.busy, 0);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic reset_midway(input int after);
    repeat (after) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk_reset_outputs();
    wq.delete(); dq.delete();
    bus.mouse_click = 1'b0; bus.clear_req = 1'b0; bus.fb_stall = 1'b0;
    m_valid = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); chk("busy_post_reset", bus.busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [6:0] lx, ly;
    logic [1:0] ls;
    logic [8:0] lc;
    bus.mouse_x = '0; bus.mouse_y = '0; bus.mouse_click = 1'b0; bus.brush_size = '0;
    bus.color = '0; bus.clear_req = 1'b0; bus.fb_stall = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;

    do_op(7'd10,  7'd20,  2'd0, 9'h1C0, 0, 0, 0);   // single pixel at 0x0A0A
    do_op(7'd10,  7'd20,  2'd0, 9'h1C0, 0, 0, 0);   // held, unchanged: nothing
    do_op(7'd10,  7'd20,  2'd0, 9'h03F, 0, 0, 0);   // colour change restamps
    do_op(7'd10,  7'd20,  2'd0, 9'h03F, 0, 1, 0);   // release and re-press
    do_op(7'd5,   7'd5,   2'd3, 9'h0AA, 0, 1, 0);   // 4x4 square
    do_op(7'd126, 7'd127, 2'd3, 9'h155, 0, 1, 0);   // corner clipping
    do_op(7'd60,  7'd60,  2'd3, 9'h0F0, 2, 1, 0);   // three stall cycles mid-stamp
`ifndef CLEAR_SWEEP_EN
    bus.clear_req = 1'b1;
    do_op(7'd60,  7'd60,  2'd3, 9'h0F0, 0, 0, 0);   // clear request has no effect
    bus.clear_req = 1'b0;
`endif

    lx = 7'd0; ly = 7'd0; ls = 2'd0; lc = 9'h0;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        lx = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(124, 127)) : 7'($urandom_range(0, 127));
        ly = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(124, 127)) : 7'($urandom_range(0, 127));
        ls = 2'($urandom_range(0, 3));
        lc = 9'($urandom_range(0, 511));
      end
      do_op(lx, ly, ls, lc, 1, ($urandom_range(0, 3) == 0), 0);
    end

    // Reset in the middle of a stamp burst.
    bus.mouse_x = 7'd40; bus.mouse_y = 7'd40; bus.brush_size = 2'd3; bus.color = 9'h0C3;
    bus.mouse_click = 1'b1;
    push_stamp(40, 40, 3, 9'h0C3);
    reset_midway(6);
    do_op(7'd40, 7'd40, 2'd3, 9'h0C3, 0, 0, 0);      // record was wiped: stamps again

`ifdef CLEAR_SWEEP_EN
    do_op(7'd30, 7'd30, 2'd1, 9'h111, 0, 1, 1);      // clear queued behind a stamp
    bus.mouse_click = 1'b0;
    bus.clear_req = 1'b1;
    for (int a = 0; a < 16384; a++) wq.push_back({14'(a), 9'h1FF});
    @(posedge clk); #1;
    bus.clear_req = 1'b0;
    reset_midway(50);                                  // reset mid-sweep
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("writes_drained", wq.size(), 0);
    chk("dones_drained",  dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
`default_nettype wire
